// File: rtl/spi_slave.sv
// SPI slave (responder) for the SCLK/MOSI/MISO/SS_N pin set.
// All SPI inputs are oversampled into the i_clk domain and edge-detected there.
// Received words come out with a one-cycle o_rx_valid strobe. Transmit words
// are accepted through a one-deep valid/ready holding register.
//
// Optional feature macro: SPI_SLAVE_MISO_OE_EN adds o_spi_miso_oe, which is high
// only while a transfer is active so MISO can be tristated on a shared bus.
//
// Ports:
//   i_clk, i_rst         system clock, asynchronous active-high reset
//   i_spi_sclk           SPI clock from the master
//   i_spi_mosi           master-out data
//   i_spi_ss_n           slave select, active-low
//   o_spi_miso           slave-out data (tx shifter MSB)
//   o_spi_miso_oe        MISO output enable (SPI_SLAVE_MISO_OE_EN builds only)
//   i_tx_data/i_tx_valid next word to transmit; taken when i_tx_valid && o_tx_ready
//   o_tx_ready           holding register empty
//   o_tx_underrun        1-cycle pulse: word load found the holding register empty
//   o_rx_data            last complete received word
//   o_rx_valid           1-cycle pulse: o_rx_data updated
//   o_busy               synchronised slave select asserted
module spi_slave #(
   parameter int unsigned           DATA_WIDTH  = 8,
   parameter bit                    CPOL        = 1'b0,
   parameter bit                    CPHA        = 1'b0,
   parameter int unsigned           SYNC_STAGES = 2,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = '1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_spi_sclk,
   input  logic                  i_spi_mosi,
   input  logic                  i_spi_ss_n,
   output logic                  o_spi_miso,
`ifdef SPI_SLAVE_MISO_OE_EN
   output logic                  o_spi_miso_oe,
`endif
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   input  logic                  i_tx_valid,
   output logic                  o_tx_ready,
   output logic                  o_tx_underrun,
   output logic [DATA_WIDTH-1:0] o_rx_data,
   output logic                  o_rx_valid,
   output logic                  o_busy
);

   localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

   typedef enum logic {StIdle, StActive} state_t;

   state_t                  state;
   logic [SYNC_STAGES-1:0]  sclk_sync, mosi_sync, ss_sync;
   logic                    sclk_prev, ss_prev;
   logic [CntW-1:0]         bit_cnt;
   logic                    word_end;
   logic [DATA_WIDTH-1:0]   rx_shift, tx_shift, hold, rx_data;
   logic                    hold_full, rx_valid, underrun, busy;

   logic sclk_s, mosi_s, ss_s;
   logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
   logic ss_fall, ss_rise, active_ok, load, accept;

   // Synchronisers. SCLK and SS_N reset to their idle levels so that reset
   // release does not look like an edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sclk_sync <= {SYNC_STAGES{CPOL}};
         mosi_sync <= '0;
         ss_sync   <= '1;
         sclk_prev <= CPOL;
         ss_prev   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], i_spi_ss_n};
         sclk_prev <= sclk_sync[SYNC_STAGES-1];
         ss_prev   <= ss_sync[SYNC_STAGES-1];
      end
   end

   always_comb begin
      sclk_s      = sclk_sync[SYNC_STAGES-1];
      mosi_s      = mosi_sync[SYNC_STAGES-1];
      ss_s        = ss_sync[SYNC_STAGES-1];
      sclk_rise   = sclk_s & ~sclk_prev;
      sclk_fall   = ~sclk_s & sclk_prev;
      lead_edge   = CPOL ? sclk_fall : sclk_rise;
      trail_edge  = CPOL ? sclk_rise : sclk_fall;
      sample_edge = CPHA ? trail_edge : lead_edge;
      shift_edge  = CPHA ? lead_edge : trail_edge;
      ss_fall     = ~ss_s & ss_prev;
      ss_rise     = ss_s & ~ss_prev;
      // Deselect beats any clock edge seen in the same cycle.
      active_ok   = (state == StActive) && !ss_rise;
      accept      = i_tx_valid && !hold_full;
      load        = 1'b0;
      if (state == StIdle) begin
         load = ss_fall && !CPHA;
      end else if (active_ok) begin
         // CPHA=0: first shift edge after a word's last sample.
         // CPHA=1: leading edge of bit 0.
         load = CPHA ? (shift_edge && (bit_cnt == '0)) : (shift_edge && word_end);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= StIdle;
         bit_cnt   <= '0;
         word_end  <= 1'b0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         underrun  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         underrun <= 1'b0;
         busy     <= ~ss_s;

         // A load reads the holding register's prior contents; an accept in
         // the same cycle is kept for the next load.
         if (accept) begin
            hold      <= i_tx_data;
            hold_full <= 1'b1;
         end else if (load) begin
            hold_full <= 1'b0;
         end

         if (load) begin
            tx_shift <= hold_full ? hold : DEFAULT_TX;
            underrun <= ~hold_full;
         end else if (active_ok && shift_edge) begin
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
         end

         case (state)
            StIdle: begin
               if (ss_fall) begin
                  state    <= StActive;
                  bit_cnt  <= '0;
                  word_end <= 1'b0;
               end
            end
            StActive: begin
               if (ss_rise) begin
                  // Abort: partial word is dropped, counter restarts.
                  state    <= StIdle;
                  bit_cnt  <= '0;
                  word_end <= 1'b0;
               end else begin
                  if (shift_edge) word_end <= 1'b0;
                  if (sample_edge) begin
                     rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                     if (bit_cnt == LastBit) begin
                        bit_cnt  <= '0;
                        word_end <= 1'b1;
                        rx_data  <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                        rx_valid <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + CntW'(1);
                     end
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign o_spi_miso    = tx_shift[DATA_WIDTH-1];
   assign o_tx_ready    = ~hold_full;
   assign o_tx_underrun = underrun;
   assign o_rx_data     = rx_data;
   assign o_rx_valid    = rx_valid;
   assign o_busy        = busy;
`ifdef SPI_SLAVE_MISO_OE_EN
   assign o_spi_miso_oe = (state == StActive);
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one mode-0 instance (defaults) and one CPOL=1/CPHA=1
// instance driven by a behavioural master at SCLK = clk/16.
module tb_spi_slave;

   localparam int HALF = 8;

   logic clk, rst;

   logic       sclk0, mosi0, ss0, miso0, txv0, txr0, und0, rxv0, busy0;
   logic [7:0] txd0, rxd0;
   logic       sclk3, mosi3, ss3, miso3, txv3, txr3, und3, rxv3, busy3;
   logic [7:0] txd3, rxd3;
`ifdef SPI_SLAVE_MISO_OE_EN
   logic       oe0, oe3;
`endif

   spi_slave u_dut0 (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_spi_sclk   (sclk0),
      .i_spi_mosi   (mosi0),
      .i_spi_ss_n   (ss0),
      .o_spi_miso   (miso0),
`ifdef SPI_SLAVE_MISO_OE_EN
      .o_spi_miso_oe(oe0),
`endif
      .i_tx_data    (txd0),
      .i_tx_valid   (txv0),
      .o_tx_ready   (txr0),
      .o_tx_underrun(und0),
      .o_rx_data    (rxd0),
      .o_rx_valid   (rxv0),
      .o_busy       (busy0)
   );

   spi_slave #(.CPOL(1'b1), .CPHA(1'b1)) u_dut3 (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_spi_sclk   (sclk3),
      .i_spi_mosi   (mosi3),
      .i_spi_ss_n   (ss3),
      .o_spi_miso   (miso3),
`ifdef SPI_SLAVE_MISO_OE_EN
      .o_spi_miso_oe(oe3),
`endif
      .i_tx_data    (txd3),
      .i_tx_valid   (txv3),
      .o_tx_ready   (txr3),
      .o_tx_underrun(und3),
      .o_rx_data    (rxd3),
      .o_rx_valid   (rxv3),
      .o_busy       (busy3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitors: every rx word and underrun pulse per instance.
   logic [7:0] rxq0[$];
   logic [7:0] rxq3[$];
   int und0_cnt = 0;
   int und3_cnt = 0;
   always @(negedge clk) begin
      if (rxv0) rxq0.push_back(rxd0);
      if (rxv3) rxq3.push_back(rxd3);
      if (und0) und0_cnt <= und0_cnt + 1;
      if (und3) und3_cnt <= und3_cnt + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_sclk(input int m, input logic v);
      if (m == 0) sclk0 = v; else sclk3 = v;
   endtask
   task automatic set_mosi(input int m, input logic v);
      if (m == 0) mosi0 = v; else mosi3 = v;
   endtask
   task automatic set_ss(input int m, input logic v);
      if (m == 0) ss0 = v; else ss3 = v;
   endtask
   function automatic logic get_miso(input int m);
      return (m == 0) ? miso0 : miso3;
   endfunction
   function automatic logic get_ready(input int m);
      return (m == 0) ? txr0 : txr3;
   endfunction
   function automatic logic get_busy(input int m);
      return (m == 0) ? busy0 : busy3;
   endfunction
   function automatic logic [7:0] get_rxd(input int m);
      return (m == 0) ? rxd0 : rxd3;
   endfunction
   function automatic int rx_count(input int m);
      return (m == 0) ? rxq0.size() : rxq3.size();
   endfunction
   function automatic int und_count(input int m);
      return (m == 0) ? und0_cnt : und3_cnt;
   endfunction
`ifdef SPI_SLAVE_MISO_OE_EN
   function automatic logic get_oe(input int m);
      return (m == 0) ? oe0 : oe3;
   endfunction
`endif

   // Push one word into the holding register, waiting (bounded) for ready.
   task automatic write_tx(input int m, input logic [7:0] d);
      for (int k = 0; k < 64; k++) begin
         if (get_ready(m)) break;
         wait_clk(1);
      end
      check("tx_ready before write", get_ready(m), 1'b1);
      if (m == 0) begin txd0 = d; txv0 = 1'b1; end
      else begin txd3 = d; txv3 = 1'b1; end
      wait_clk(1);
      if (m == 0) txv0 = 1'b0; else txv3 = 1'b0;
   endtask

   task automatic select(input int m);
      set_ss(m, 1'b0);
      wait_clk(HALF);
   endtask

   task automatic deselect(input int m);
      wait_clk(HALF);
      set_ss(m, 1'b1);
      wait_clk(2 * HALF);
   endtask

   // Master side: MSB first; MISO captured at the master's sample edge.
   task automatic xfer(input int m, input logic [7:0] mo, input int nbits,
                       output logic [7:0] mi);
      mi = '0;
      for (int i = 0; i < nbits; i++) begin
         if (m == 0) begin
            set_mosi(m, mo[7-i]);
            wait_clk(HALF);
            mi = {mi[6:0], get_miso(m)};
            set_sclk(m, 1'b1);
            wait_clk(HALF);
            set_sclk(m, 1'b0);
         end else begin
            set_sclk(m, 1'b0);
            set_mosi(m, mo[7-i]);
            wait_clk(HALF);
            mi = {mi[6:0], get_miso(m)};
            set_sclk(m, 1'b1);
            wait_clk(HALF);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " miso"},     miso0, 1'b0);
      check({tag, " tx_ready"}, txr0,  1'b1);
      check({tag, " underrun"}, und0,  1'b0);
      check({tag, " rx_data"},  rxd0,  8'h00);
      check({tag, " rx_valid"}, rxv0,  1'b0);
      check({tag, " busy"},     busy0, 1'b0);
   endtask

   typedef struct {
      int         m;
      logic       pre_en;
      logic [7:0] pre;
      logic       refill;   // write a filler word once the first load has emptied holding
      logic [7:0] mosi;
      logic [7:0] exp_rx;
      logic [7:0] exp_miso;
      int         exp_und;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [7:0] mi, mi2;
      int rx_base, und_base;

      // Mode 0 with refill: no underrun anywhere in the frame.
      vecs[0] = '{m: 0, pre_en: 1'b1, pre: 8'h3C, refill: 1'b1, mosi: 8'hA5,
                  exp_rx: 8'hA5, exp_miso: 8'h3C, exp_und: 0};
      // Mode 0 empty: underrun at select and again at the load after the last bit.
      vecs[1] = '{m: 0, pre_en: 1'b0, pre: 8'h00, refill: 1'b0, mosi: 8'h12,
                  exp_rx: 8'h12, exp_miso: 8'hFF, exp_und: 2};
      vecs[2] = '{m: 3, pre_en: 1'b1, pre: 8'h96, refill: 1'b0, mosi: 8'h69,
                  exp_rx: 8'h69, exp_miso: 8'h96, exp_und: 0};
      vecs[3] = '{m: 3, pre_en: 1'b1, pre: 8'h69, refill: 1'b0, mosi: 8'h96,
                  exp_rx: 8'h96, exp_miso: 8'h69, exp_und: 0};
      // Mode 3 empty: only the bit-0 leading-edge load underruns.
      vecs[4] = '{m: 3, pre_en: 1'b0, pre: 8'h00, refill: 1'b0, mosi: 8'h5A,
                  exp_rx: 8'h5A, exp_miso: 8'hFF, exp_und: 1};

      rst = 1'b1;
      sclk0 = 1'b0; mosi0 = 1'b0; ss0 = 1'b1; txd0 = '0; txv0 = 1'b0;
      sclk3 = 1'b1; mosi3 = 1'b0; ss3 = 1'b1; txd3 = '0; txv3 = 1'b0;
      wait_clk(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      wait_clk(4);
      check_reset_outputs("post-reset");

      // Single-frame vectors.
      for (int v = 0; v < 5; v++) begin
         if (vecs[v].pre_en) write_tx(vecs[v].m, vecs[v].pre);
         rx_base  = rx_count(vecs[v].m);
         und_base = und_count(vecs[v].m);
         select(vecs[v].m);
         check($sformatf("v%0d busy in frame", v), get_busy(vecs[v].m), 1'b1);
`ifdef SPI_SLAVE_MISO_OE_EN
         check($sformatf("v%0d oe in frame", v), get_oe(vecs[v].m), 1'b1);
`endif
         if (vecs[v].refill) write_tx(vecs[v].m, 8'h00);
         xfer(vecs[v].m, vecs[v].mosi, 8, mi);
         deselect(vecs[v].m);
         check($sformatf("v%0d busy idle", v), get_busy(vecs[v].m), 1'b0);
`ifdef SPI_SLAVE_MISO_OE_EN
         check($sformatf("v%0d oe idle", v), get_oe(vecs[v].m), 1'b0);
`endif
         check($sformatf("v%0d rx pulses", v), rx_count(vecs[v].m) - rx_base, 1);
         check($sformatf("v%0d rx_data", v), get_rxd(vecs[v].m), vecs[v].exp_rx);
         check($sformatf("v%0d miso word", v), mi, vecs[v].exp_miso);
         check($sformatf("v%0d underruns", v), und_count(vecs[v].m) - und_base,
               vecs[v].exp_und);
      end

      // Back-to-back words in one frame.
      write_tx(0, 8'h01);
      rx_base = rx_count(0);
      select(0);
      write_tx(0, 8'h02);
      xfer(0, 8'h55, 8, mi);
      xfer(0, 8'hAA, 8, mi2);
      deselect(0);
      check("b2b rx pulses", rx_count(0) - rx_base, 2);
      if (rx_count(0) - rx_base == 2) begin
         check("b2b rx word0", rxq0[rx_base], 8'h55);
         check("b2b rx word1", rxq0[rx_base + 1], 8'hAA);
      end
      check("b2b miso word0", mi, 8'h01);
      check("b2b miso word1", mi2, 8'h02);

      // Abort after 5 bits; the word written during the aborted frame survives.
      write_tx(0, 8'hB4);
      rx_base = rx_count(0);
      select(0);
      write_tx(0, 8'hD2);
      xfer(0, 8'hFF, 5, mi);
      deselect(0);
      check("abort no rx", rx_count(0) - rx_base, 0);
      check("abort ready", txr0, 1'b0);
      select(0);
      xfer(0, 8'hC3, 8, mi);
      deselect(0);
      check("post-abort rx pulses", rx_count(0) - rx_base, 1);
      check("post-abort rx_data", rxd0, 8'hC3);
      check("post-abort miso word", mi, 8'hD2);

      // Reset at bit 3.
      write_tx(0, 8'h44);
      select(0);
      xfer(0, 8'h7E, 3, mi);
      rst = 1'b1;
      wait_clk(1);
      check_reset_outputs("mid-reset");
      ss0 = 1'b1;
      sclk0 = 1'b0;
      wait_clk(4);
      rst = 1'b0;
      rx_base  = rx_count(0);
      und_base = und_count(0);
      wait_clk(2 * HALF);
      check("after reset no rx", rx_count(0) - rx_base, 0);
      check("after reset tx_ready", txr0, 1'b1);
      select(0);
      xfer(0, 8'h7E, 8, mi);
      deselect(0);
      check("after reset rx pulses", rx_count(0) - rx_base, 1);
      check("after reset rx_data", rxd0, 8'h7E);
      check("after reset miso word", mi, 8'hFF);
      check("after reset underruns", und_count(0) - und_base, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
